spdif_sample_pairer: RTL and testbench

//  Downstream of the S/PDIF DAI receiver: takes its per-subframe 24b sample strobes (data/ack/lrck/locked),

---
 rtl/spdif_sample_pairer.sv | 212 +++++++++++++++++++++
 tb/tb_spdif_sample_pairer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spdif_sample_pairer.sv
// spdif_sample_pairer
//   Pairs left/right S/PDIF subframe strobes into stereo frames. Frames are
//   held in a small first-word-fall-through FIFO and handed to the consumer
//   over a valid/ready handshake. Sticky flags report overflow and pairing
//   errors.
//   Optional build macro SPDIF_PAIR_STATS_EN adds drop_cnt_o, a saturating
//   16-bit count of dropped frames and discarded samples.
module spdif_sample_pairer #(
    parameter int FIFO_DEPTH_LOG2 = 2,
    parameter int SAMPLE_W        = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SAMPLE_W-1:0]        data_i,
    input  logic                       ack_i,
    input  logic                       lrck_i,
    input  logic                       locked_i,
    output logic [SAMPLE_W-1:0]        left_o,
    output logic [SAMPLE_W-1:0]        right_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       overflow_o,
    output logic                       pair_err_o,
    input  logic                       clr_i,
`ifdef SPDIF_PAIR_STATS_EN
    output logic [15:0]                drop_cnt_o,
`endif
    output logic [FIFO_DEPTH_LOG2:0]   level_o
);

    localparam int AW    = FIFO_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;
    localparam int FW    = 2 * SAMPLE_W;

    typedef enum logic {
        IDLE   = 1'b0,
        HAVE_L = 1'b1
    } pair_state_t;

    // ------------------------------------------------------------------
    // Pairing FSM signals
    // ------------------------------------------------------------------
    pair_state_t           state_reg, state_next;
    logic [SAMPLE_W-1:0]   hold_reg, hold_next;
    logic                  push_req;
    logic                  pair_err_evt;

    // ------------------------------------------------------------------
    // FIFO signals
    // ------------------------------------------------------------------
    logic [FW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr_reg, rd_ptr_reg;
    logic [AW-1:0]         rd_ptr_plus1;
    logic [AW:0]           level_reg, level_next;
    logic [FW-1:0]         head_reg, head_next;
    logic [FW-1:0]         wr_data;
    logic                  full;
    logic                  pop;
    logic                  push_ok;
    logic                  overflow_evt;
    logic                  overflow_reg;
    logic                  pair_err_reg;

    // Pair FSM state and left-sample hold register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
        end
    end

    // Pair FSM next state: strobes only count while the receiver is locked;
    // losing lock abandons any held left sample.
    always_comb begin
        state_next   = state_reg;
        hold_next    = hold_reg;
        push_req     = 1'b0;
        pair_err_evt = 1'b0;
        if (!locked_i) begin
            state_next = IDLE;
        end else if (ack_i) begin
            case (state_reg)
                IDLE: begin
                    if (!lrck_i) begin
                        hold_next  = data_i;
                        state_next = HAVE_L;
                    end else begin
                        pair_err_evt = 1'b1;
                    end
                end
                HAVE_L: begin
                    if (lrck_i) begin
                        push_req   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        hold_next    = data_i;
                        pair_err_evt = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign wr_data      = {hold_reg, data_i};
    assign full         = (level_reg == (AW+1)'(DEPTH));
    assign pop          = valid_o && ready_i;
    // A full FIFO still accepts a frame when the head leaves on the same edge.
    assign push_ok      = push_req && (!full || pop);
    assign overflow_evt = push_req && full && !pop;
    assign rd_ptr_plus1 = rd_ptr_reg + 1'b1;

    // Frame storage: write-only array, read through the registered head
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Occupancy and registered head: head tracks the oldest stored frame,
    // taking the incoming frame directly when it becomes the oldest.
    always_comb begin
        level_next = level_reg;
        head_next  = head_reg;
        case ({push_ok, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
        if (pop) begin
            if (level_reg == (AW+1)'(1)) begin
                if (push_ok) begin
                    head_next = wr_data;
                end
            end else begin
                head_next = mem[rd_ptr_plus1];
            end
        end else if (push_ok && (level_reg == '0)) begin
            head_next = wr_data;
        end
    end

    // FIFO pointers, level and head register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_plus1;
            end
            level_reg <= level_next;
            head_reg  <= head_next;
        end
    end

    // Sticky error flags: a new event outranks a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg <= 1'b0;
            pair_err_reg <= 1'b0;
        end else begin
            if (overflow_evt) begin
                overflow_reg <= 1'b1;
            end else if (clr_i) begin
                overflow_reg <= 1'b0;
            end
            if (pair_err_evt) begin
                pair_err_reg <= 1'b1;
            end else if (clr_i) begin
                pair_err_reg <= 1'b0;
            end
        end
    end

`ifdef SPDIF_PAIR_STATS_EN
    logic [15:0] drop_cnt_reg;
    logic        drop_evt;

    // Overflow drops and pairing discards never coincide, so one increment suffices
    assign drop_evt = overflow_evt || pair_err_evt;

    // Saturating drop counter; an event on a clearing cycle restarts at 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_reg <= '0;
        end else if (clr_i) begin
            drop_cnt_reg <= drop_evt ? 16'd1 : 16'd0;
        end else if (drop_evt && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_reg;
`endif

    assign valid_o    = (level_reg != '0);
    assign level_o    = level_reg;
    assign left_o     = head_reg[FW-1:SAMPLE_W];
    assign right_o    = head_reg[SAMPLE_W-1:0];
    assign overflow_o = overflow_reg;
    assign pair_err_o = pair_err_reg;

endmodule

// File: tb/tb_spdif_sample_pairer.sv
// tb_spdif_sample_pairer
//   Directed tests for spdif_sample_pairer at the default depth of 4 frames.
//   Expected values are hand-derived constants.
module tb_spdif_sample_pairer;

    logic        clk;
    logic        rst_n;
    logic [23:0] data_i;
    logic        ack_i;
    logic        lrck_i;
    logic        locked_i;
    logic [23:0] left_o;
    logic [23:0] right_o;
    logic        valid_o;
    logic        ready_i;
    logic        overflow_o;
    logic        pair_err_o;
    logic        clr_i;
    logic [2:0]  level_o;
`ifdef SPDIF_PAIR_STATS_EN
    logic [15:0] drop_cnt_o;
`endif

    int checks;
    int errors;

    spdif_sample_pairer #(
        .FIFO_DEPTH_LOG2(2),
        .SAMPLE_W(24)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .data_i(data_i),
        .ack_i(ack_i),
        .lrck_i(lrck_i),
        .locked_i(locked_i),
        .left_o(left_o),
        .right_o(right_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .overflow_o(overflow_o),
        .pair_err_o(pair_err_o),
        .clr_i(clr_i),
`ifdef SPDIF_PAIR_STATS_EN
        .drop_cnt_o(drop_cnt_o),
`endif
        .level_o(level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic lr, input logic [23:0] d);
        ack_i  = 1'b1;
        lrck_i = lr;
        data_i = d;
        tick();
        ack_i  = 1'b0;
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r);
        send(1'b0, l);
        send(1'b1, r);
    endtask

    task automatic clear_flags();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (valid_o !== 1'b0 || level_o !== 3'd0 || left_o !== 24'd0 || right_o !== 24'd0 ||
            overflow_o !== 1'b0 || pair_err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b level=%0d left=%h right=%h ovf=%b perr=%b, required all zero",
                     valid_o, level_o, left_o, right_o, overflow_o, pair_err_o);
        end
`ifdef SPDIF_PAIR_STATS_EN
        checks++;
        if (drop_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt_o);
        end
`endif
        $display("test_reset: valid=%b level=%0d", valid_o, level_o);
    endtask

    task automatic test_basic_pair();
        send(1'b0, 24'h123456);
        ready_i = 1'b1;
        send(1'b1, 24'hABCDEF);
        checks++;
        if (valid_o !== 1'b1 || left_o !== 24'h123456 || right_o !== 24'hABCDEF || level_o !== 3'd1) begin
            errors++;
            $display("FAIL basic_head: valid=%b left=%h right=%h level=%0d, required 1 123456 abcdef 1",
                     valid_o, left_o, right_o, level_o);
        end
        tick();
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL basic_pop: valid=%b level=%0d, required 0 0", valid_o, level_o);
        end
        $display("test_basic_pair: frame 123456/abcdef pushed and popped");
    endtask

    task automatic test_back_to_back();
        // level 1 with push and pop on the same edge: new frame becomes head
        send_frame(24'h800001, 24'hFF0001);
        send(1'b0, 24'h800002);
        ready_i = 1'b1;
        send(1'b1, 24'hFF0002);
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b1 || level_o !== 3'd1 || left_o !== 24'h800002 || right_o !== 24'hFF0002) begin
            errors++;
            $display("FAIL b2b_level1: valid=%b level=%0d left=%h right=%h, required 1 1 800002 ff0002",
                     valid_o, level_o, left_o, right_o);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: valid=%b, required 0", valid_o);
        end
        $display("test_back_to_back: simultaneous push/pop at level 1");
    endtask

    task automatic test_overflow();
        logic [23:0] l;
        logic [23:0] r;
        for (int k = 1; k <= 5; k++) begin
            l = 24'h100000 + 24'(k);
            r = 24'h200000 + 24'(k);
            send_frame(l, r);
            if (k == 4) begin
                checks++;
                if (level_o !== 3'd4 || overflow_o !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_fill4: level=%0d ovf=%b, required 4 0", level_o, overflow_o);
                end
            end
        end
        checks++;
        if (level_o !== 3'd4 || overflow_o !== 1'b1 || left_o !== 24'h100001 || right_o !== 24'h200001) begin
            errors++;
            $display("FAIL ovf_fifth: level=%0d ovf=%b left=%h right=%h, required 4 1 100001 200001",
                     level_o, overflow_o, left_o, right_o);
        end
        ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            l = 24'h100000 + 24'(k);
            r = 24'h200000 + 24'(k);
            checks++;
            if (valid_o !== 1'b1 || left_o !== l || right_o !== r) begin
                errors++;
                $display("FAIL ovf_drain%0d: valid=%b left=%h right=%h, required 1 %h %h",
                         k, valid_o, left_o, right_o, l, r);
            end
            tick();
        end
        ready_i = 1'b0;
        checks++;
        if (valid_o !== 1'b0 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL ovf_empty: valid=%b level=%0d, required 0 0", valid_o, level_o);
        end
        clear_flags();
        checks++;
        if (overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: ovf=%b, required 0", overflow_o);
        end
        $display("test_overflow: 5 pushed into depth 4, drained 4");
    endtask

    task automatic test_pair_errors();
        clear_flags();
        send(1'b1, 24'h0000AA);
        checks++;
        if (pair_err_o !== 1'b1 || level_o !== 3'd0) begin
            errors++;
            $display("FAIL perr_orphan: perr=%b level=%0d, required 1 0", pair_err_o, level_o);
        end
        // orphan right coinciding with clear: the event wins
        clr_i = 1'b1;
        send(1'b1, 24'h0000BB);
        clr_i = 1'b0;
        checks++;
        if (pair_err_o !== 1'b1) begin
            errors++;
            $display("FAIL perr_clr_collide: perr=%b, required 1", pair_err_o);
        end
        clear_flags();
        checks++;
        if (pair_err_o !== 1'b0) begin
            errors++;
            $display("FAIL perr_clear: perr=%b, required 0", pair_err_o);
        end
        send(1'b0, 24'hAAAAAA);
        send(1'b0, 24'hBBBBBB);
        send(1'b1, 24'hCCCCCC);
        checks++;
        if (pair_err_o !== 1'b1 || level_o !== 3'd1 || left_o !== 24'hBBBBBB || right_o !== 24'hCCCCCC) begin
            errors++;
            $display("FAIL perr_llr: perr=%b level=%0d left=%h right=%h, required 1 1 bbbbbb cccccc",
                     pair_err_o, level_o, left_o, right_o);
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
        clear_flags();
        $display("test_pair_errors: orphan right and L,L,R sequence");
    endtask

    task automatic test_lock_loss();
        send(1'b0, 24'h555555);
        locked_i = 1'b0;
        tick();
        locked_i = 1'b1;
        send(1'b1, 24'h666666);
        checks++;
        if (pair_err_o !== 1'b1 || level_o !== 3'd0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL lock_loss: perr=%b level=%0d valid=%b, required 1 0 0",
                     pair_err_o, level_o, valid_o);
        end
        clear_flags();
        $display("test_lock_loss: held left discarded");
    endtask

    task automatic test_full_push_pop();
        logic [23:0] l;
        logic [23:0] r;
        for (int k = 1; k <= 4; k++) begin
            l = 24'h300000 + 24'(k);
            r = 24'h400000 + 24'(k);
            send_frame(l, r);
        end
        send(1'b0, 24'h300005);
        ready_i = 1'b1;
        send(1'b1, 24'h400005);
        ready_i = 1'b0;
        checks++;
        if (level_o !== 3'd4 || overflow_o !== 1'b0 || left_o !== 24'h300002) begin
            errors++;
            $display("FAIL full_pushpop: level=%0d ovf=%b left=%h, required 4 0 300002",
                     level_o, overflow_o, left_o);
        end
        ready_i = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            l = 24'h300000 + 24'(k);
            r = 24'h400000 + 24'(k);
            checks++;
            if (valid_o !== 1'b1 || left_o !== l || right_o !== r) begin
                errors++;
                $display("FAIL full_drain%0d: valid=%b left=%h right=%h, required 1 %h %h",
                         k, valid_o, left_o, right_o, l, r);
            end
            tick();
        end
        ready_i = 1'b0;
        $display("test_full_push_pop: push and pop on full edge");
    endtask

    task automatic test_async_reset();
        for (int k = 1; k <= 3; k++) begin
            send_frame(24'h700000 + 24'(k), 24'h710000 + 24'(k));
        end
        checks++;
        if (level_o !== 3'd3) begin
            errors++;
            $display("FAIL areset_pre: level=%0d, required 3", level_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid_o !== 1'b0 || level_o !== 3'd0 || left_o !== 24'd0) begin
            errors++;
            $display("FAIL areset_now: valid=%b level=%0d left=%h, required 0 0 0",
                     valid_o, level_o, left_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("test_async_reset: mid-stream reset at level 3");
    endtask

    task automatic test_stats();
`ifdef SPDIF_PAIR_STATS_EN
        for (int k = 1; k <= 7; k++) begin
            send_frame(24'h900000 + 24'(k), 24'h910000 + 24'(k));
        end
        checks++;
        if (drop_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL stats_count: got %0d, required 3", drop_cnt_o);
        end
        clear_flags();
        checks++;
        if (drop_cnt_o !== 16'd0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL stats_clear: cnt=%0d ovf=%b, required 0 0", drop_cnt_o, overflow_o);
        end
        $display("test_stats: 3 drops counted and cleared");
`else
        $display("test_stats: statistics counter not built");
`endif
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b0;
        data_i   = '0;
        ack_i    = 1'b0;
        lrck_i   = 1'b0;
        locked_i = 1'b1;
        ready_i  = 1'b0;
        clr_i    = 1'b0;
        tick();
        tick();
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_basic_pair();
        test_back_to_back();
        test_overflow();
        test_pair_errors();
        test_lock_loss();
        test_full_push_pop();
        test_async_reset();
        test_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
